// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes
// and the alignment rule used when a request is accepted.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  // Size code 11 behaves exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane alignment: extracts a load value from a RAM word and merges
// store data into a previously read word (little-endian lanes).
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rword,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lanes ignore addr_lo[0] so a tolerated misaligned half stays in-word.
  always_comb begin
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    half_sel = rword[{addr_lo[1], 4'b0000} +: 16];
    ldata    = rword;
    mdata    = wdata;
    case (size)
      SZ_BYTE: begin
        ldata = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
        mdata = base_word;
        mdata[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        mdata = base_word;
        mdata[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ldata = rword;
        mdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit driving a word-wide RAM with async read and
// sync write; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MISALIGN_ERR = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_datain,
  output logic        ram_we,
  input  logic [31:0] ram_dataout
);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rword_q;
  logic [1:0]  size_q;
  logic        signed_q, we_q;
  logic [31:0] ldata, mdata;
  logic        accept, misal_req;

  assign accept    = req_valid && req_ready;
  assign misal_req = (MISALIGN_ERR != 0) && is_misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (misal_req)      state_nxt = ST_RESP;
          else if (!req_we)   state_nxt = ST_RD;
          else if (req_size[1]) state_nxt = ST_WR;
          else                state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ram_we is decoded from state so an async reset kills a pending write at once.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    ram_we     = (state == ST_WR);
    ram_addr   = '0;
    ram_datain = '0;
    if (state == ST_RD || state == ST_WR) ram_addr = {addr_q[31:2], 2'b00};
    if (state == ST_WR) ram_datain = size_q[1] ? wdata_q : mdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rword_q    <= '0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        signed_q   <= req_signed;
        we_q       <= req_we;
        resp_err   <= misal_req;
        resp_rdata <= '0;
      end
      if (state == ST_RD) begin
        rword_q <= ram_dataout;
        if (!we_q) resp_rdata <= ldata;
      end
    end
  end

  mem_lane_align u_lane (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .rword     (ram_dataout),
    .base_word (rword_q),
    .wdata     (wdata_q),
    .ldata     (ldata),
    .mdata     (mdata)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-word RAM model, directed cases and a
// randomized sweep checked against a shadow-memory reference model.
module tb_mem_access_unit;

  logic        clock, reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr, ram_datain, ram_dataout;
  logic        ram_we;

  logic [31:0] ram     [32];
  logic [31:0] ref_mem [32];
  logic [31:0] last_rdata, last_datain;
  int n_chk, n_fail;

  mem_access_unit #(.MISALIGN_ERR(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_addr(ram_addr),
    .ram_datain(ram_datain), .ram_we(ram_we), .ram_dataout(ram_dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_dataout = ram[ram_addr[6:2]];
  always @(posedge clock) if (ram_we) ram[ram_addr[6:2]] <= ram_datain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int sz, sh, idx, exp_lat, we_cnt, lat;
    logic mis;
    logic [31:0] word, mask, val, nw, exp_rd, wd, wa;
    bit got;
    sz   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis  = (int'(addr & 32'h3) % sz) != 0;
    sh   = (sz == 4) ? 0 : (int'(addr & 32'h3) / sz) * sz;
    mask = (sz == 1) ? 32'hff : (sz == 2) ? 32'hffff : 32'hffffffff;
    idx  = int'((addr >> 2) & 32'h1f);
    word = ref_mem[idx];
    exp_rd = 32'd0;
    nw     = word;
    if (!mis && !we) begin
      val = (word >> (8 * sh)) & mask;
      if (sgn && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
      exp_rd = val;
    end
    if (!mis && we) nw = (word & ~(mask << (8 * sh))) | ((wdata & mask) << (8 * sh));
    exp_lat = mis ? 1 : (!we) ? 2 : (sz == 4) ? 2 : 3;

    @(negedge clock);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    got = 0; lat = 0; we_cnt = 0; wd = 32'd0; wa = 32'd0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clock);
      if (ram_we) begin we_cnt++; wd = ram_datain; wa = ram_addr; end
      if (resp_valid) begin got = 1; lat = c; end
    end
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", lat, exp_lat);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, mis});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (ram_we) we_cnt++;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    chk("we_cycles", we_cnt, (we && !mis) ? 1 : 0);
    if (we && !mis && we_cnt == 1) begin
      chk("ram_datain", wd, nw);
      chk("ram_addr", wa, {addr[31:2], 2'b00});
      ref_mem[idx] = nw;
    end
    last_rdata  = resp_rdata;
    last_datain = wd;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v, a;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      if (i == 0)  v = 32'hbf800000;
      if (i == 14) v = 32'h000000a3;
      if (i == 15) v = 32'h00000027;
      if (i == 16) v = 32'h00000079;
      ram[i] <= v;
      ref_mem[i] = v;
    end
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_datain", ram_datain, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_req(1'b0, 2'b00, 1'b1, 32'h03, 32'd0, 0);
    chk("lb_signed", last_rdata, 32'hffffffbf);
    do_req(1'b0, 2'b00, 1'b0, 32'h03, 32'd0, 1);
    chk("lbu", last_rdata, 32'h000000bf);
    do_req(1'b0, 2'b01, 1'b1, 32'h02, 32'd0, 0);
    chk("lh_signed", last_rdata, 32'hffffbf80);
    do_req(1'b0, 2'b01, 1'b0, 32'h00, 32'd0, 0);
    chk("lhu", last_rdata, 32'h00000000);
    do_req(1'b1, 2'b00, 1'b0, 32'h39, 32'h0000005a, 0);
    chk("sb_datain", last_datain, 32'h00005aa3);
    do_req(1'b0, 2'b10, 1'b0, 32'h3a, 32'd0, 0);
    chk("lw_misal_rdata", last_rdata, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 4);
    chk("lw_hold", last_rdata, 32'h00000079);
    do_req(1'b0, 2'b11, 1'b1, 32'h40, 32'd0, 0);
    chk("lw_size3", last_rdata, 32'h00000079);

    // Reset while the read half of a halfword store is in flight.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h3c; req_wdata = 32'h0000beef;
    @(posedge clock);
    #1 req_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("rst_mid_we", {31'd0, ram_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_hold_we", {31'd0, ram_we}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_word15", ram[15], 32'h00000027);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             a, $urandom, $urandom_range(0, 3));
    end

    @(negedge clock);
    for (int i = 0; i < 32; i++) chk("ram_final", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MISALIGN_ERR, default 1, meaning that a nonzero value flags misaligned half/word requests and suppresses their RAM access.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 req_signed  in  1  sign-extend load result when 1.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  CPU accepts response.
REQ-013 resp_rdata  out  32  load result (0 for stores).
REQ-014 resp_err  out  1  misaligned request flag.
REQ-015 ram_addr  out  32  word RAM address; the RAM decodes ram_addr[6:2].
REQ-016 ram_datain  out  32  word written to RAM.
REQ-017 ram_we  out  1  RAM write enable, sampled on the RAM's clock edge.
REQ-018 ram_dataout  in  32  combinational RAM read data.

Function
REQ-019 The unit SHALL be the initiator for the word-only, async-read/sync-write data RAM and SHALL provide byte/halfword/word loads and stores with little-endian lanes (addr[1:0]=0 selects bits 7:0).
REQ-020 FSM states SHALL be IDLE, RD, WR and RESP; the request is accepted when req_valid&&req_ready, and address, size, signed, we and wdata are latched.
REQ-021 Transitions from IDLE: misaligned (half with addr[0]=1, or word with addr[1:0]!=0, and MISALIGN_ERR=1) goes to RESP with err=1; load goes to RD; word store goes to WR; byte/half store goes to RD.
REQ-022 In RD the unit SHALL drive ram_addr={addr[31:2],2'b00}, capture ram_dataout, and go to RESP for a load or to WR for a sub-word store.
REQ-023 In WR the unit SHALL drive ram_we=1 for exactly one cycle with ram_datain equal to wdata (word) or the captured word with only the addressed byte/half lanes replaced, then go to RESP.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err held stable until resp_ready; the unit returns to IDLE on resp_valid&&resp_ready.
REQ-025 Latency from accept to resp_valid SHALL be: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, misaligned 1 cycle.
REQ-026 Load extraction SHALL shift the selected lane to bit 0 and zero-extend, or sign-extend when req_signed=1; a word load ignores req_signed.
REQ-027 ram_we SHALL be 0 in every state except WR; misaligned requests SHALL never assert ram_we.
REQ-028 ram_addr outside RAM depth SHALL not be flagged; aliasing via addr[6:2] is the RAM's behaviour.

Reset
REQ-029 Reset SHALL force IDLE and set req_ready=1 and resp_valid, resp_err, resp_rdata, ram_we, ram_datain and ram_addr to 0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no RAM write, including during WR, because ram_we drops immediately.

Structure
REQ-031 State encodings and the req_size codes SHALL reside in the shared CPU package.
REQ-032 Lane extraction/merge SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-033 RAM word0=0xbf800000: lb signed @0x03 -> resp_rdata=0xffffffbf at accept+2; lbu @0x03 -> 0x000000bf.
REQ-034 lh signed @0x02 -> 0xffffbf80; lhu @0x00 -> 0x00000000.
REQ-035 Word14=0x000000a3, sb 0x5A @0x39 -> ram_we high exactly 1 cycle with ram_datain=0x00005aa3; resp_valid at accept+3.
REQ-036 lw @0x3A -> resp_err=1 at accept+1, ram_we never high, resp_rdata=0.
REQ-037 Reset asserted in RD of sh @0x3C -> ram_we stays 0, RAM word15 unchanged (0x00000027), req_ready=1 after release.
REQ-038 resp_ready held low for 4 cycles after a lw @0x40 (0x00000079) -> resp_valid/resp_rdata stable, req_ready=0 throughout; the next request is accepted the cycle after the handshake.
